entropy_src_window_ht: RTL and testbench
========================================

# entropy_src_window_ht

Windowed ones-count health test for the entropy source noise path. Over a window of `window_i` valid RNG samples, it counts the total number of `1` bits across all lanes. At each window close it publishes the count as a registered value, raises a one-cycle done event and raises high/low threshold fail pulses. Its `test_cnt_o`/`test_done_pulse_o` pair feeds the high/low watermark registers directly downstream, on their `value_i`/`event_i`.

## Interface
Parameters:
- `RngBusWidth`, 4: number of parallel RNG lanes per sample.
- `RegWidth`, 16: width of the window, threshold and count fields.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `entropy_bit_i`, in, RngBusWidth: RNG sample, one bit per lane.
- `entropy_bit_vld_i`, in, 1: sample valid, qualified by `active_i`.
- `active_i`, in, 1: test enable. When low, internal counters are held at 0.
- `clear_i`, in, 1: synchronous clear of counters and outputs.
- `window_i`, in, RegWidth: samples per window. 0 means the test never closes a window.
- `thresh_hi_i`, in, RegWidth: fail-high threshold.
- `thresh_lo_i`, in, RegWidth: fail-low threshold.
- `test_cnt_o`, out, RegWidth: ones count of the last completed window.
- `test_done_pulse_o`, out, 1: one-cycle pulse per completed window.
- `test_fail_hi_pulse_o`, out, 1: completed window had count > `thresh_hi_i`.
- `test_fail_lo_pulse_o`, out, 1: completed window had count < `thresh_lo_i`.
- `window_wrap_pulse_o`, out, 1: one-cycle pulse on the closing sample's cycle (combinational from flops and inputs).
- `sat_o`, out, 1: sticky flag, set when the ones accumulator saturated; cleared only by `clear_i` or reset.

## Operation
- State:
  - `samp_cnt_q` (RegWidth): valid samples accepted in the current window.
  - `ones_acc_q` (RegWidth): saturating sum of ones.
  - `test_cnt_o`, `test_done_pulse_o`, both fail pulses and `sat_o`, all flops.
- Popcount: `pc` = number of ones in `entropy_bit_i`, width $clog2(RngBusWidth+1), zero-extended to RegWidth.
- Accept: `acc_en` = `active_i` & `entropy_bit_vld_i` & (`window_i` != 0).
- Close: `close` = `acc_en` & (`samp_cnt_q` + 1 >= `window_i`).
  - Uses `>=`, so lowering `window_i` mid-window closes on the next accepted sample.
- `sum` = `ones_acc_q` + `pc`, saturating at all-ones. Saturation sets `sat_o`.
- Priority per cycle, highest first:
  1. `clear_i`: counters, `test_cnt_o` and `sat_o` go to 0; no pulses.
  2. `!active_i`: counters go to 0; `test_cnt_o` and `sat_o` hold; no pulses.
  3. `close`: `test_cnt_o` <= `sum`; done pulse <= 1; fail_hi <= (`sum` > `thresh_hi_i`); fail_lo <= (`sum` < `thresh_lo_i`); counters go to 0.
  4. `acc_en`: `samp_cnt_q` += 1; `ones_acc_q` <= `sum`.
  5. Otherwise hold. Pulses are 0 in any cycle without a close.
- Comparisons are unsigned, full RegWidth.
- Thresholds are sampled in the closing cycle only.
- `samp_cnt_q` cannot wrap, because a close always occurs at or before `window_i`.

## Timing
- Reset values:
  - `test_cnt_o` = 0; `sat_o` = 0.
  - All pulses 0; `samp_cnt_q` = 0; `ones_acc_q` = 0.
- Latency: the closing sample is presented in cycle N.
  - `window_wrap_pulse_o` is high in cycle N.
  - `test_cnt_o`, done and fail pulses are valid in cycle N+1, for exactly one cycle each (`test_cnt_o` then holds).
- Throughput: one sample per cycle, with no bubbles at window boundaries. The first sample of the next window may arrive in cycle N+1.
- The downstream watermark samples `test_cnt_o` in the same cycle as `test_done_pulse_o`. No handshake and no backpressure.
- `clear_i` in cycle N together with `close` suppresses the done and fail pulses in N+1.
- `rst_ni` asserted mid-window discards the partial window immediately (asynchronous).

## Test plan
- Window 4, `RngBusWidth` 4, four valid `4'b1111` samples back-to-back, `thresh_hi` 15 -> cycle after the 4th sample: `test_cnt_o` = 16, done = 1, fail_hi = 1, fail_lo = 0; all pulses 0 the following cycle.
- Window 3, samples `4'b0001`, `4'b0000`, `4'b0011` with idle valid-low cycles between them, `thresh_lo` 4 -> `test_cnt_o` = 3, fail_lo = 1, done exactly once.
- Back-to-back windows (window 2, continuous `4'b0101`) -> done pulse every 2 cycles, each with `test_cnt_o` = 4, and no sample lost at the boundary.
- `clear_i` asserted in the closing cycle -> no done pulse, `test_cnt_o` = 0; `active_i` low mid-window -> partial count discarded and next window counts from 0.
- `RegWidth` 4, window 8, all-ones samples -> `test_cnt_o` = 15 (saturated), `sat_o` = 1 until `clear_i`.
- `window_i` = 0 with 100 valid samples -> no pulses; `window_i` lowered from 10 to 2 after 5 samples -> close on the next accepted sample.

Source files
------------

// File: rtl/entropy_src_window_ht.sv
// entropy_src_window_ht: windowed ones-count health test.
// Publishes a saturating ones count and threshold fail pulses per window.
module entropy_src_window_ht #(
    parameter int RngBusWidth = 4,
    parameter int RegWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [RngBusWidth-1:0] entropy_bit_i,
    input  logic                   entropy_bit_vld_i,
    input  logic                   active_i,
    input  logic                   clear_i,
    input  logic [RegWidth-1:0]    window_i,
    input  logic [RegWidth-1:0]    thresh_hi_i,
    input  logic [RegWidth-1:0]    thresh_lo_i,
    output logic [RegWidth-1:0]    test_cnt_o,
    output logic                   test_done_pulse_o,
    output logic                   test_fail_hi_pulse_o,
    output logic                   test_fail_lo_pulse_o,
    output logic                   window_wrap_pulse_o,
    output logic                   sat_o
);

    localparam int PcW = $clog2(RngBusWidth + 1);

    logic [RegWidth-1:0] samp_cnt_q;
    logic [RegWidth-1:0] ones_acc_q;
    logic [PcW-1:0]      pc;
    logic [RegWidth:0]   sum_wide;
    logic [RegWidth:0]   samp_nxt;
    logic [RegWidth-1:0] sum;
    logic                sum_ovf;
    logic                acc_en;
    logic                close;

    // Popcount of the current sample across all lanes.
    always_comb begin
        pc = '0;
        for (int i = 0; i < RngBusWidth; i++) begin
            pc = pc + PcW'(entropy_bit_i[i]);
        end
    end

    // One extra bit catches accumulator overflow and window overrun.
    assign sum_wide = {1'b0, ones_acc_q} + (RegWidth + 1)'(pc);
    assign sum_ovf  = sum_wide[RegWidth];
    assign sum      = sum_ovf ? '1 : sum_wide[RegWidth-1:0];
    assign samp_nxt = {1'b0, samp_cnt_q} + (RegWidth + 1)'(1);

    assign acc_en = active_i & entropy_bit_vld_i & (window_i != '0);
    assign close  = acc_en & (samp_nxt >= {1'b0, window_i});

    assign window_wrap_pulse_o = close;

    // Window sample counter and ones accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_cnt_q <= '0;
            ones_acc_q <= '0;
        end else if (clear_i || !active_i || close) begin
            samp_cnt_q <= '0;
            ones_acc_q <= '0;
        end else if (acc_en) begin
            samp_cnt_q <= samp_nxt[RegWidth-1:0];
            ones_acc_q <= sum;
        end
    end

    // Published count, window pulses and sticky saturation flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            test_cnt_o           <= '0;
            test_done_pulse_o    <= 1'b0;
            test_fail_hi_pulse_o <= 1'b0;
            test_fail_lo_pulse_o <= 1'b0;
            sat_o                <= 1'b0;
        end else begin
            test_done_pulse_o    <= 1'b0;
            test_fail_hi_pulse_o <= 1'b0;
            test_fail_lo_pulse_o <= 1'b0;
            if (clear_i) begin
                test_cnt_o <= '0;
                sat_o      <= 1'b0;
            end else if (acc_en) begin
                if (sum_ovf) begin
                    sat_o <= 1'b1;
                end
                if (close) begin
                    test_cnt_o           <= sum;
                    test_done_pulse_o    <= 1'b1;
                    test_fail_hi_pulse_o <= (sum > thresh_hi_i);
                    test_fail_lo_pulse_o <= (sum < thresh_lo_i);
                end
            end
        end
    end

endmodule

// File: tb/tb_entropy_src_window_ht.sv
// tb_entropy_src_window_ht: table vectors, corner sequences and
// randomized stimulus against a count-based reference model.
module tb_entropy_src_window_ht;

    localparam int MAX16 = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  bits = '0;
    logic        vld = 1'b0;
    logic        act = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] win = '0;
    logic [15:0] thi = '0;
    logic [15:0] tlo = '0;
    logic [3:0]  w4 = '0;
    logic [3:0]  thi4 = '0;
    logic [3:0]  tlo4 = '0;

    logic [15:0] cnt;
    logic        done, fhi, flo, wrap, sat;
    logic [3:0]  cnt4;
    logic        done4, fhi4, flo4, wrap4, sat4;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int   m_n, m_tot;
    int   m_cnt;
    logic m_done, m_hi, m_lo, m_sat;
    logic last_wrap, exp_wrap;

    always #5 clk = ~clk;

    entropy_src_window_ht #(.RngBusWidth(4), .RegWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .entropy_bit_i(bits), .entropy_bit_vld_i(vld),
        .active_i(act), .clear_i(clr),
        .window_i(win), .thresh_hi_i(thi), .thresh_lo_i(tlo),
        .test_cnt_o(cnt), .test_done_pulse_o(done),
        .test_fail_hi_pulse_o(fhi), .test_fail_lo_pulse_o(flo),
        .window_wrap_pulse_o(wrap), .sat_o(sat)
    );

    entropy_src_window_ht #(.RngBusWidth(4), .RegWidth(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .entropy_bit_i(bits), .entropy_bit_vld_i(vld),
        .active_i(act), .clear_i(clr),
        .window_i(w4), .thresh_hi_i(thi4), .thresh_lo_i(tlo4),
        .test_cnt_o(cnt4), .test_done_pulse_o(done4),
        .test_fail_hi_pulse_o(fhi4), .test_fail_lo_pulse_o(flo4),
        .window_wrap_pulse_o(wrap4), .sat_o(sat4)
    );

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_tot = 0; m_cnt = 0;
        m_done = 0; m_hi = 0; m_lo = 0; m_sat = 0;
    endtask

    task automatic model_step();
        m_done = 0; m_hi = 0; m_lo = 0;
        if (clr) begin
            m_n = 0; m_tot = 0; m_cnt = 0; m_sat = 0;
        end else if (!act) begin
            m_n = 0; m_tot = 0;
        end else if (vld && win != 0) begin
            m_n++;
            m_tot += $countones(bits);
            if (m_tot > MAX16) begin
                m_sat = 1;
                m_tot = MAX16;
            end
            if (m_n >= int'(win)) begin
                m_cnt  = m_tot;
                m_done = 1;
                m_hi   = (m_tot > int'(thi));
                m_lo   = (m_tot < int'(tlo));
                m_n = 0; m_tot = 0;
            end
        end
    endtask

    // One clock: wrap checked mid-cycle, registered outputs after the edge.
    task automatic cyc();
        @(negedge clk);
        exp_wrap = act && vld && (win != 0) && (m_n + 1 >= int'(win));
        last_wrap = wrap;
        chk("model_wrap", wrap, exp_wrap);
        model_step();
        @(posedge clk);
        #1;
        chk("model_cnt", cnt, m_cnt);
        chk("model_done", done, m_done);
        chk("model_hi", fhi, m_hi);
        chk("model_lo", flo, m_lo);
        chk("model_sat", sat, m_sat);
    endtask

    typedef struct {
        logic        clr, act, vld;
        logic [3:0]  bits;
        logic [15:0] win, thi, tlo;
        logic        e_wrap, e_done, e_hi, e_lo;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic a, logic v, logic [3:0] b,
                                logic [15:0] w, logic [15:0] h,
                                logic [15:0] l, logic ew, logic ed,
                                logic eh, logic el, logic [15:0] ec);
        vec_t r;
        r.clr = c; r.act = a; r.vld = v; r.bits = b;
        r.win = w; r.thi = h; r.tlo = l;
        r.e_wrap = ew; r.e_done = ed; r.e_hi = eh; r.e_lo = el;
        r.e_cnt = ec;
        return r;
    endfunction

    int pulses;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk("rst_sat4", sat4, 0);
        rst_n = 1'b1;
        act = 1'b1;

        // window 4, all ones, fail high
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,4'hF,4,15,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,4'hF,4,15,0, 1,1,1,0,16));
        tbl.push_back(mk(0,1,0,4'h0,4,15,0, 0,0,0,0,16));
        // window 3 with gaps, fail low
        tbl.push_back(mk(0,1,1,4'h1,3,15,4, 0,0,0,0,16));
        tbl.push_back(mk(0,1,0,4'h0,3,15,4, 0,0,0,0,16));
        tbl.push_back(mk(0,1,1,4'h0,3,15,4, 0,0,0,0,16));
        tbl.push_back(mk(0,1,0,4'h0,3,15,4, 0,0,0,0,16));
        tbl.push_back(mk(0,1,1,4'h3,3,15,4, 1,1,0,1,3));
        tbl.push_back(mk(0,1,0,4'h0,3,15,4, 0,0,0,0,3));
        // back-to-back windows of 2
        tbl.push_back(mk(0,1,1,4'h5,2,15,0, 0,0,0,0,3));
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(0,1,1,4'h5,2,15,0, 1,1,0,0,4));
            tbl.push_back(mk(0,1,1,4'h5,2,15,0, 0,0,0,0,4));
        end
        tbl.push_back(mk(0,1,1,4'h5,2,15,0, 1,1,0,0,4));
        tbl.push_back(mk(0,1,0,4'h0,2,15,0, 0,0,0,0,4));
        // clear on the closing sample
        tbl.push_back(mk(0,1,1,4'h1,2,15,0, 0,0,0,0,4));
        tbl.push_back(mk(1,1,1,4'h1,2,15,0, 1,0,0,0,0));
        // inactive mid-window discards the partial count
        tbl.push_back(mk(0,1,1,4'hF,3,15,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,4'hF,3,15,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,4'hF,3,15,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,4'h1,3,15,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,4'h1,3,15,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,4'h1,3,15,0, 1,1,0,0,3));

        foreach (tbl[i]) begin
            clr = tbl[i].clr; act = tbl[i].act; vld = tbl[i].vld;
            bits = tbl[i].bits; win = tbl[i].win;
            thi = tbl[i].thi; tlo = tbl[i].tlo;
            cyc();
            chk("tbl_wrap", last_wrap, tbl[i].e_wrap);
            chk("tbl_done", done, tbl[i].e_done);
            chk("tbl_hi", fhi, tbl[i].e_hi);
            chk("tbl_lo", flo, tbl[i].e_lo);
            chk("tbl_cnt", cnt, tbl[i].e_cnt);
        end
        clr = 0; act = 1; vld = 0;
        cyc();
        chk("tbl_after_done", done, 0);

        // RegWidth 4, window 8, all ones: saturates
        win = 0; w4 = 8; thi4 = 14; tlo4 = 0;
        vld = 1; bits = 4'hF;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 3) chk("sat4_set", sat4, 1);
            if (i < 7) chk("sat4_nodone", done4, 0);
        end
        chk("sat4_wrap", last_wrap, 0);
        chk("sat4_cnt", cnt4, 15);
        chk("sat4_done", done4, 1);
        chk("sat4_hi", fhi4, 1);
        vld = 0;
        repeat (3) cyc();
        chk("sat4_hold", sat4, 1);
        chk("sat4_pulse_off", done4, 0);
        clr = 1;
        cyc();
        clr = 0;
        chk("sat4_clr", sat4, 0);
        chk("sat4_clr_cnt", cnt4, 0);
        w4 = 0;

        // window 0: never closes
        win = 0; pulses = 0;
        for (int i = 0; i < 100; i++) begin
            vld = 1; bits = 4'($urandom);
            cyc();
            pulses += int'(done) + int'(last_wrap);
        end
        chk("win0_pulses", pulses, 0);

        // lowering the window mid-way closes on the next sample
        win = 10; bits = 4'h1;
        for (int i = 0; i < 5; i++) cyc();
        win = 2;
        cyc();
        chk("lower_wrap", last_wrap, 1);
        chk("lower_done", done, 1);
        chk("lower_cnt", cnt, 6);

        // async reset mid-window
        win = 3; bits = 4'hF;
        repeat (2) cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 0);
        rst_n = 1'b1;
        model_reset();
        bits = 4'h1;
        repeat (3) cyc();
        chk("async_rst_done", done, 1);
        chk("async_rst_win", cnt, 3);

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(19) == 0) begin
                case ($urandom_range(5))
                    0: win = 0;
                    1: win = 1;
                    2: win = 2;
                    3: win = 3;
                    4: win = 5;
                    default: win = 7;
                endcase
            end
            clr  = ($urandom_range(39) == 0);
            act  = ($urandom_range(14) != 0);
            vld  = ($urandom_range(3) != 0);
            bits = 4'($urandom);
            thi  = 16'($urandom_range(20));
            tlo  = 16'($urandom_range(20));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
